m_turn_scheduler: RTL and testbench

Game-level controller for the connect-four datapath. It owns both player fields and the piled-count array, and alternates turns between the user and the AI. It time-shares one external combinational piler between both players, launches and bounds the AI tree search, and samples an external combinational win checker after every committed move. It sits between the input/debounce logic and the display renderer, replacing ad-hoc turn logic.

---
 rtl/m_turn_scheduler_if.sv | 26 ++
 rtl/m_turn_scheduler.sv | 134 +++++++++++++
 tb/tb_m_turn_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/m_turn_scheduler_if.sv
// m_turn_scheduler_if: bus between the turn scheduler and its piler, AI search core and win checker
//   master (scheduler): drives o_pl_field/o_pl_piled/o_pl_col, o_ai_en, o_wc_field
//                       samples i_pl_valid/i_pl_field/i_pl_piled, i_ai_valid/i_ai_finished/i_ai_col, i_wc_win
//   slave (datapath blocks): the mirror image
interface m_turn_scheduler_if;
   logic [41:0] o_pl_field;
   logic [20:0] o_pl_piled;
   logic [2:0]  o_pl_col;
   logic        i_pl_valid;
   logic [41:0] i_pl_field;
   logic [20:0] i_pl_piled;
   logic        o_ai_en;
   logic        i_ai_valid;
   logic        i_ai_finished;
   logic [2:0]  i_ai_col;
   logic [41:0] o_wc_field;
   logic        i_wc_win;
   modport master (
      output o_pl_field, o_pl_piled, o_pl_col, o_ai_en, o_wc_field,
      input  i_pl_valid, i_pl_field, i_pl_piled, i_ai_valid, i_ai_finished, i_ai_col, i_wc_win
   );
   modport slave (
      input  o_pl_field, o_pl_piled, o_pl_col, o_ai_en, o_wc_field,
      output i_pl_valid, i_pl_field, i_pl_piled, i_ai_valid, i_ai_finished, i_ai_col, i_wc_win
   );
endinterface

// File: rtl/m_turn_scheduler.sv
// m_turn_scheduler: connect-four game controller alternating user and AI turns over a shared piler
//   w_clk, w_rst (sync, active-low), w_start (new game), w_user_input (INC/DEC/OK one-hot pulses)
//   bus: piler, AI search and win-checker signals (m_turn_scheduler_if.master)
//   o_state, o_selecting_col, o_your_field, o_ai_field, o_winner, o_move_count: registered game status
module m_turn_scheduler #(
   parameter int AI_TIMEOUT   = 1_000_000,
   parameter bit FIRST_PLAYER = 1'b0
) (
   input  logic                w_clk,
   input  logic                w_rst,
   input  logic                w_start,
   input  logic [3:0]          w_user_input,
   m_turn_scheduler_if.master  bus,
   output logic [2:0]          o_state,
   output logic [2:0]          o_selecting_col,
   output logic [41:0]         o_your_field,
   output logic [41:0]         o_ai_field,
   output logic [1:0]          o_winner,
   output logic [5:0]          o_move_count
);
   localparam int TW = $clog2(AI_TIMEOUT);
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_YOUR_TURN = 3'd1,
      S_CHECK     = 3'd2,
      S_YOUR_PILE = 3'd3,
      S_AI_SEARCH = 3'd4,
      S_AI_PILE   = 3'd6,
      S_GAME_OVER = 3'd7
   } state_t;
   state_t        r_state, w_next;
   logic [41:0]   r_your_field, r_ai_field;
   logic [20:0]   r_piled;
   logic [2:0]    r_col, w_low;
   logic [5:0]    r_moves;
   logic [1:0]    r_winner;
   logic [TW-1:0] r_tmo;
   logic          r_mover, r_ai_seen;
   logic          w_inc, w_dec, w_ok, w_tmo_hit, w_ai_done;
   assign w_inc     = w_user_input == 4'b0001;
   assign w_dec     = w_user_input == 4'b0010;
   assign w_ok      = w_user_input == 4'b0100;
   assign w_tmo_hit = r_tmo == TW'(AI_TIMEOUT - 1);
   assign w_ai_done = bus.i_ai_valid && bus.i_ai_finished;
   // lowest column whose disc count is below 6; scanned high-to-low so the lowest wins
   always_comb begin
      w_low = 3'd0;
      for (int c = 6; c >= 0; c--)
         if (r_piled[3*c +: 3] < 3'd6) w_low = 3'(c);
   end
   always_ff @(posedge w_clk)
      if (!w_rst) r_state <= S_IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_GAME_OVER: if (w_start) w_next = FIRST_PLAYER ? S_AI_SEARCH : S_YOUR_TURN;
         S_YOUR_TURN:         if (w_ok) w_next = S_YOUR_PILE;
         S_YOUR_PILE:         w_next = bus.i_pl_valid ? S_CHECK : S_YOUR_TURN;
         S_CHECK:             w_next = (bus.i_wc_win || r_moves == 6'd42) ? S_GAME_OVER :
                                       r_mover ? S_YOUR_TURN : S_AI_SEARCH;
         S_AI_SEARCH:         if (w_ai_done || w_tmo_hit) w_next = S_AI_PILE;
         S_AI_PILE:           if (bus.i_pl_valid) w_next = S_CHECK;
         default:             w_next = S_IDLE;
      endcase
   end
   // the piler only ever sees the field of the side currently piling
   always_comb begin
      bus.o_pl_field = (r_state == S_YOUR_PILE) ? r_your_field :
                       (r_state == S_AI_PILE)   ? r_ai_field   : '0;
      bus.o_pl_piled = r_piled;
      bus.o_pl_col   = r_col;
      bus.o_ai_en    = r_state == S_AI_SEARCH;
      bus.o_wc_field = r_mover ? r_ai_field : r_your_field;
   end
   always_ff @(posedge w_clk) begin
      if (!w_rst) begin
         r_your_field <= '0;
         r_ai_field   <= '0;
         r_piled      <= '0;
         r_col        <= '0;
         r_moves      <= '0;
         r_winner     <= '0;
         r_tmo        <= '0;
         r_mover      <= 1'b0;
         r_ai_seen    <= 1'b0;
      end else begin
         r_tmo     <= (r_state == S_AI_SEARCH) ? r_tmo + TW'(1) : '0;
         r_ai_seen <= (r_state == S_AI_SEARCH) && (r_ai_seen || bus.i_ai_valid);
         case (r_state)
            S_IDLE, S_GAME_OVER:
               if (w_start) begin
                  r_your_field <= '0;
                  r_ai_field   <= '0;
                  r_piled      <= '0;
                  r_col        <= '0;
                  r_moves      <= '0;
                  r_winner     <= '0;
               end
            S_YOUR_TURN:
               if (w_inc)      r_col <= (r_col == 3'd6) ? 3'd0 : r_col + 3'd1;
               else if (w_dec) r_col <= (r_col == 3'd0) ? 3'd6 : r_col - 3'd1;
            S_YOUR_PILE:
               if (bus.i_pl_valid) begin
                  r_your_field <= bus.i_pl_field;
                  r_piled      <= bus.i_pl_piled;
                  r_moves      <= r_moves + 6'd1;
                  r_mover      <= 1'b0;
               end
            S_CHECK:
               if (bus.i_wc_win)          r_winner <= r_mover ? 2'b10 : 2'b01;
               else if (r_moves == 6'd42) r_winner <= 2'b11;
            // r_col already tracks the last valid suggestion; only fall back when none arrived
            S_AI_SEARCH:
               if (bus.i_ai_valid)                  r_col <= bus.i_ai_col;
               else if (w_tmo_hit && !r_ai_seen)    r_col <= w_low;
            S_AI_PILE:
               if (bus.i_pl_valid) begin
                  r_ai_field <= bus.i_pl_field;
                  r_piled    <= bus.i_pl_piled;
                  r_moves    <= r_moves + 6'd1;
                  r_mover    <= 1'b1;
               end else r_col <= w_low;
            default: ;
         endcase
      end
   end
   assign o_state         = r_state;
   assign o_selecting_col = r_col;
   assign o_your_field    = r_your_field;
   assign o_ai_field      = r_ai_field;
   assign o_winner        = r_winner;
   assign o_move_count    = r_moves;
endmodule

// File: tb/tb_m_turn_scheduler.sv
// tb_m_turn_scheduler: directed bench with piler, AI search and vertical-win models
module tb_m_turn_scheduler;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [3:0]  uin;
   logic [2:0]  st, col;
   logic [41:0] yf, af;
   logic [1:0]  win;
   logic [5:0]  mc;
   int          total = 0, bad = 0;
   int          ai_cnt, ai_dly, exp_mc;
   logic        ai_v_en, ai_f_en, wc;
   logic [2:0]  ai_c, cur, pl_cnt;
   logic [20:0] pl_p;
   logic [41:0] exp_y, exp_a;
   localparam logic [3:0] INC = 4'b0001, DEC = 4'b0010, OK = 4'b0100;
   m_turn_scheduler_if pif();
   m_turn_scheduler #(.AI_TIMEOUT(16), .FIRST_PLAYER(1'b0)) dut (
      .w_clk(clk), .w_rst(rst), .w_start(start), .w_user_input(uin), .bus(pif),
      .o_state(st), .o_selecting_col(col), .o_your_field(yf), .o_ai_field(af),
      .o_winner(win), .o_move_count(mc)
   );
   always #5 clk = ~clk;
   // piler: disc lands at bit 6*col + count
   always_comb begin
      pl_cnt = pif.o_pl_piled[3*pif.o_pl_col +: 3];
      pl_p = pif.o_pl_piled;
      pl_p[3*pif.o_pl_col +: 3] = pl_cnt + 3'd1;
      pif.i_pl_valid = pl_cnt < 3'd6;
      pif.i_pl_field = pif.o_pl_field | (42'd1 << (6*pif.o_pl_col + pl_cnt));
      pif.i_pl_piled = pl_p;
   end
   // win checker: vertical fours only
   always_comb begin
      wc = 1'b0;
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 3; r++)
            if (&pif.o_wc_field[6*c+r +: 4]) wc = 1'b1;
      pif.i_wc_win = wc;
   end
   // AI search: valid from its second enabled cycle, finished once ai_cnt reaches ai_dly
   always_ff @(posedge clk) ai_cnt <= pif.o_ai_en ? ai_cnt + 1 : 0;
   assign pif.i_ai_valid    = pif.o_ai_en && ai_v_en && ai_cnt >= 1;
   assign pif.i_ai_finished = pif.o_ai_en && ai_f_en && ai_cnt >= ai_dly;
   assign pif.i_ai_col      = ai_c;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic press(input logic [3:0] code);
      uin = code;
      step();
      uin = 4'b0000;
   endtask
   task automatic go_col(input logic [2:0] c);
      while (cur != c) begin
         press(INC);
         cur = (cur == 3'd6) ? 3'd0 : cur + 3'd1;
      end
   endtask
   task automatic play_round(input logic [2:0] uc, input logic [2:0] ac, input logic [2:0] es, input int dm);
      int n;
      ai_c = ac;
      go_col(uc);
      press(OK);
      n = 0;
      while (st != 3'd1 && st != 3'd7 && n < 60) begin
         step();
         n++;
      end
      exp_mc += dm;
      chk("round_state", st, es);
      chk("round_moves", mc, exp_mc);
      cur = (dm == 2) ? ac : uc;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
   initial begin
      rst = 1'b0; start = 1'b0; uin = 4'b0000;
      ai_v_en = 1'b1; ai_f_en = 1'b1; ai_dly = 5; ai_c = 3'd3; cur = 3'd0; exp_mc = 0;
      step(); step();
      chk("rst_state", st, 0);
      chk("rst_col", col, 0);
      chk("rst_yf", yf, 0);
      chk("rst_af", af, 0);
      chk("rst_mc", mc, 0);
      chk("rst_win", win, 0);
      chk("rst_ai_en", pif.o_ai_en, 0);
      rst = 1'b1;
      step();
      chk("idle_hold", st, 0);
      start = 1'b1; step(); start = 1'b0;
      chk("start_turn", st, 1);
      press(DEC);
      chk("dec_wrap", col, 6);
      chk("dec_state", st, 1);
      press(INC);
      chk("inc_wrap", col, 0);
      go_col(3'd3);
      chk("col3", col, 3);
      chk("pl_field_idle", pif.o_pl_field, 0);
      press(OK);
      chk("ok_pile", st, 3);
      step();
      chk("u_check", st, 2);
      chk("u_field", yf, 42'd1 << 18);
      chk("u_mc", mc, 1);
      chk("wc_field", pif.o_wc_field, 42'd1 << 18);
      step();
      chk("ai_search", st, 4);
      chk("ai_en", pif.o_ai_en, 1);
      repeat (5) step();
      chk("ai_wait", st, 4);
      step();
      chk("ai_pile", st, 6);
      chk("ai_col", col, 3);
      chk("ai_en_fall", pif.o_ai_en, 0);
      step();
      chk("ai_check", st, 2);
      chk("ai_field", af, 42'd1 << 19);
      chk("ai_mc", mc, 2);
      step();
      chk("back_turn", st, 1);
      chk("piled", pif.o_pl_piled, 21'h000400);
      exp_mc = 2;
      repeat (3) play_round(3'd0, 3'd0, 3'd1, 2);
      exp_y = (42'd1 << 18) | 42'h15;
      exp_a = (42'd1 << 19) | 42'h2A;
      chk("col0_yf", yf, exp_y);
      chk("col0_af", af, exp_a);
      press(OK);
      chk("full_pile", st, 3);
      step();
      chk("full_back", st, 1);
      chk("full_mc", mc, 8);
      chk("full_yf", yf, exp_y);
      chk("full_col", col, 0);
      ai_f_en = 1'b0; ai_c = 3'd5;
      go_col(3'd4);
      press(OK); step(); step();
      chk("tmo_entry", st, 4);
      repeat (15) step();
      chk("tmo_hold", st, 4);
      step();
      chk("tmo_exit", st, 6);
      chk("tmo_col", col, 5);
      step();
      exp_a |= 42'd1 << 30;
      exp_y |= 42'd1 << 24;
      chk("tmo_af", af, exp_a);
      step();
      chk("tmo_turn", st, 1);
      chk("tmo_mc", mc, 10);
      cur = 3'd5; ai_v_en = 1'b0;
      go_col(3'd4);
      press(OK); step(); step();
      repeat (16) step();
      chk("nov_exit", st, 6);
      chk("nov_col", col, 1);
      step(); step();
      exp_a |= 42'd1 << 6;
      exp_y |= 42'd1 << 25;
      chk("nov_af", af, exp_a);
      chk("nov_yf", yf, exp_y);
      chk("nov_mc", mc, 12);
      cur = 3'd1; ai_v_en = 1'b1; ai_f_en = 1'b1; ai_c = 3'd0;
      go_col(3'd4);
      press(OK); step(); step();
      repeat (5) step();
      step();
      chk("fb_pile", st, 6);
      chk("fb_col_full", col, 0);
      step();
      chk("fb_retry", st, 6);
      chk("fb_col", col, 1);
      chk("fb_af_hold", af, exp_a);
      step();
      exp_a |= 42'd1 << 7;
      exp_y |= 42'd1 << 26;
      chk("fb_check", st, 2);
      chk("fb_af", af, exp_a);
      step();
      chk("fb_turn", st, 1);
      chk("fb_yf", yf, exp_y);
      chk("fb_mc", mc, 14);
      cur = 3'd1; ai_f_en = 1'b0;
      go_col(3'd6);
      press(OK); step(); step();
      chk("mid_search", st, 4);
      step(); step();
      rst = 1'b0;
      step();
      chk("mr_state", st, 0);
      chk("mr_yf", yf, 0);
      chk("mr_af", af, 0);
      chk("mr_mc", mc, 0);
      chk("mr_col", col, 0);
      chk("mr_piled", pif.o_pl_piled, 0);
      chk("mr_ai_en", pif.o_ai_en, 0);
      rst = 1'b1;
      step();
      start = 1'b1; step(); start = 1'b0;
      chk("win_start", st, 1);
      cur = 3'd0; exp_mc = 0; ai_f_en = 1'b1;
      repeat (3) play_round(3'd1, 3'd0, 3'd1, 2);
      play_round(3'd1, 3'd0, 3'd7, 1);
      chk("win_who", win, 2'b01);
      chk("win_yf", yf, 42'h3C0);
      chk("win_af", af, 42'h7);
      press(OK);
      press(INC);
      chk("go_state", st, 7);
      chk("go_col", col, 1);
      chk("go_mc", mc, 7);
      start = 1'b1; step(); start = 1'b0;
      chk("draw_start", st, 1);
      chk("draw_clr_mc", mc, 0);
      chk("draw_clr_win", win, 0);
      chk("draw_clr_yf", yf, 0);
      cur = 3'd0; exp_mc = 0;
      for (int c = 0; c < 7; c++)
         for (int k = 0; k < 3; k++)
            play_round(3'(c), 3'(c), (c == 6 && k == 2) ? 3'd7 : 3'd1, 2);
      chk("draw_win", win, 2'b11);
      chk("draw_mc", mc, 42);
      chk("draw_state", st, 7);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
